// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the runtime
// configuration record used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam int unsigned CFG_DIV_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } uart_rx_state_e;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] baud_div;
    logic [1:0]           parity_mode;
    logic                 two_stop;
  } uart_cfg_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Mode 3 is an alias for "no parity".
  function automatic logic parity_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Sample-tick prescaler: counts 0..div-1 and pulses stick_o at the terminal
// count. A divisor of 0 behaves as 1; restart_i forces the count back to 0.
module uart_os_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             stick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] term;

  always_comb begin
    term    = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    // >= so a divisor shrunk below the running count still wraps promptly
    stick_o = (cnt_q >= term);
    cnt_d   = stick_o ? '0 : cnt_q + DIV_W'(1);
    if (restart_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample voting, false-start rejection,
// break detection and a valid/ready output with sticky overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 brk,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0] OS_V0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_V1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] OS_DEC  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [1:0]           sync_q;
  logic                 rxs;
  uart_rx_state_e       state_q, state_d;
  uart_cfg_t            cfg_q, cfg_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BC_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           vote_q, vote_d;
  logic                 par_q, par_d;
  logic                 stop_err_q, stop_err_d;
  logic                 nz_q, nz_d;
  logic                 low_seen_q, low_seen_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 fe_q, fe_d, pe_q, pe_d, brk_q, brk_d;
  logic                 valid_q, valid_d, overrun_q, overrun_d;

  logic                 stick, restart, vote, mid_bit, end_bit;
  logic                 complete, comp_fe, comp_pe, comp_brk, overrun_set;
  logic [DIV_W-1:0]     div_sel;

  assign rxs     = sync_q[1];
  assign div_sel = (state_q == StIdle) ? baud_div : DIV_W'(cfg_q.baud_div);
  assign vote    = maj3(vote_q[0], vote_q[1], rxs);
  assign mid_bit = stick && (os_q == OS_DEC);
  assign end_bit = stick && (os_q == OS_LAST);

  uart_os_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .restart_i(restart),
    .div_i    (div_sel),
    .stick_o  (stick)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    vote_d      = vote_q;
    par_d       = par_q;
    stop_err_d  = stop_err_q;
    nz_d        = nz_q;
    low_seen_d  = low_seen_q;
    restart     = 1'b0;
    complete    = 1'b0;
    comp_fe     = 1'b0;
    comp_pe     = 1'b0;
    comp_brk    = 1'b0;

    if (stick && (state_q != StIdle) && (state_q != StBrkWait)) begin
      os_d = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
      if (os_q == OS_V0) vote_d[0] = rxs;
      if (os_q == OS_V1) vote_d[1] = rxs;
    end

    unique case (state_q)
      StIdle: begin
        if (stick && !rxs) begin
          state_d              = StStart;
          os_d                 = '0;
          bit_d                = '0;
          restart              = 1'b1;
          stop_err_d           = 1'b0;
          nz_d                 = 1'b0;
          cfg_d.baud_div       = CFG_DIV_W'(baud_div);
          cfg_d.parity_mode    = parity_mode;
          cfg_d.two_stop       = two_stop;
        end
      end
      StStart: begin
        if (mid_bit && vote) begin
          state_d = StIdle;
        end else if (end_bit) begin
          state_d = StData;
        end
      end
      StData: begin
        if (mid_bit) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          nz_d    = nz_q | vote;
        end
        if (end_bit) begin
          if (bit_q == BC_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = parity_en(cfg_q.parity_mode) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end
      StParity: begin
        if (mid_bit) begin
          par_d = vote;
          nz_d  = nz_q | vote;
        end
        if (end_bit) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (mid_bit) begin
          if (cfg_q.two_stop && (bit_q == '0)) begin
            stop_err_d = stop_err_q | !vote;
            nz_d       = nz_q | vote;
          end else begin
            // Finish at the decision point so a start bit right after is not missed.
            complete = 1'b1;
            comp_fe  = stop_err_q | !vote;
            comp_pe  = parity_en(cfg_q.parity_mode) &&
                       (par_q != ((^shift_q) ^ (cfg_q.parity_mode == PAR_ODD)));
            comp_brk = !(nz_q | vote);
            state_d  = comp_brk ? StBrkWait : StIdle;
          end
        end
        if (end_bit) begin
          bit_d = bit_q + BC_W'(1);
        end
      end
      StBrkWait: begin
        low_seen_d = low_seen_q | !rxs;
        if (stick) begin
          low_seen_d = 1'b0;
          if (rxs && !low_seen_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d      = data_q;
    fe_d        = fe_q;
    pe_d        = pe_q;
    brk_d       = brk_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        fe_d    = comp_fe;
        pe_d    = comp_pe;
        brk_d   = comp_brk;
      end else begin
        overrun_set = 1'b1;
      end
    end

    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (overrun_set) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= StIdle;
      cfg_q      <= '0;
      os_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      vote_q     <= '0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
      nz_q       <= 1'b0;
      low_seen_q <= 1'b0;
      data_q     <= '0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      vote_q     <= vote_d;
      par_q      <= par_d;
      stop_err_q <= stop_err_d;
      nz_q       <= nz_d;
      low_seen_q <= low_seen_d;
      data_q     <= data_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign brk        = brk_q;
  assign overrun    = overrun_q;
  // A break is already reported once the FSM sits in BRKWAIT.
  assign busy       = (state_q != StIdle) && (state_q != StBrkWait);

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver. It is the parametrised successor to the fixed-rate receiver. It adds:
- runtime baud, parity and stop-bit configuration;
- a 2-FF input synchroniser;
- 3-sample majority voting and false-start rejection;
- break detection;
- a valid/ready output handshake with overrun reporting.

It sits between the `rx` pad and any byte consumer (FIFO, command parser, loopback to the transmitter).

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame (5..9), LSB first.
- `OVERSAMPLE`, 16, sample ticks per bit; even, ≥ 8.
- `DIV_W`, 16, width of `baud_div`.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial line, idle high.
- `baud_div` in DIV_W: clk cycles per sample tick, = f_clk/(baud·OVERSAMPLE). 0 is treated as 1.
- `parity_mode` in 2: 0 none, 1 even, 2 odd, 3 none.
- `two_stop` in 1: 0 one stop bit, 1 two stop bits.
- `data_out` out DATA_BITS: received word.
- `valid` out 1: word available.
- `ready` in 1: consumer accepts the word.
- `frame_err` out 1: stop bit sampled 0; qualified by `valid`.
- `parity_err` out 1: parity mismatch; qualified by `valid`.
- `brk` out 1: break received; qualified by `valid`.
- `overrun` out 1: sticky; a completed frame was dropped.
- `overrun_clr` in 1: clears `overrun`.
- `busy` out 1: a frame is in progress.

## Operation
- **Synchroniser:** `rx` → 2 FFs; both reset to 1. All logic uses the synchronised `rxs`.
- **Prescaler:** a counter runs 0..`baud_div`-1 and emits a one-cycle `stick` at the terminal count.
  - It is free-running while in IDLE.
  - It restarts from 0 on start detection.
- **Configuration latch:** `baud_div`, `parity_mode` and `two_stop` are latched on start detection. Changes mid-frame have no effect.
- **Bit timing:** `os_cnt` runs 0..OVERSAMPLE-1 within each bit period.
  - Votes are taken at `os_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority (2 of 3), decided at OVERSAMPLE/2+1.
  - The state advances when `os_cnt` = OVERSAMPLE-1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BRKWAIT.
  - **IDLE:** when `stick` and `rxs`=0: go to START, `os_cnt`=0, `busy`=1.
  - **START:** if the vote is 1 → IDLE (glitch; nothing is output). Otherwise go to DATA at the end of the bit.
  - **DATA:** the vote is shifted in LSB first. After DATA_BITS bits → PARITY if parity is enabled, else STOP.
  - **PARITY:** store the vote. Expected value: even → XOR of data; odd → its inverse.
  - **STOP:** the vote is checked. With `two_stop`, both stop bits are checked and `frame_err` is the OR of both.
    - The frame completes at the decision point of the last stop bit, not at the bit end. This allows back-to-back start bits to be caught.
    - Completion when the stop vote is 1: go to IDLE.
    - Completion when the whole frame is 0 (data all 0, parity 0 if present, stop 0): set `brk`=1, `frame_err`=1, go to BRKWAIT.
  - **BRKWAIT:** stay until `rxs`=1 for one full `stick`, then go to IDLE.
- **Frame completion:**
  - If `valid`=0 or `ready`=1 in that cycle: load `data_out` and the flags, and assert `valid`.
  - If `valid`=1 and `ready`=0: drop the frame, set `overrun`=1, and leave the held word untouched.
- **Handshake:** the word transfers when `valid && ready`. `valid` falls on the next cycle unless a new frame completes in that same cycle, in which case it stays 1 with the new word.
- **`overrun`:** cleared by `overrun_clr`. If a set and a clear occur in the same cycle, the set wins.

## Timing
- **Reset values:** `valid`=0, `data_out`=0, `frame_err`=`parity_err`=`brk`=`overrun`=0, `busy`=0. State is IDLE and all counters are 0.
- **Reset mid-frame:** the partial frame is discarded. No `valid` is produced.
- **Input latency:** 2 clk (synchroniser), plus up to `baud_div` clk of start-detect jitter.
- **Output latency:** `valid` rises 1 clk after the last-stop decision `stick`. `busy` falls in the same cycle.
- **Output stability:** `data_out` and the flags are stable while `valid`=1.
- **Counter widths:** the prescaler is DIV_W bits, `os_cnt` is $clog2(OVERSAMPLE) bits, and the bit counter is $clog2(DATA_BITS+1) bits. All wrap only at their terminal values.

## Structure
- **Package `uart_pkg`:**
  - parity-mode constants (PAR_NONE/EVEN/ODD);
  - FSM state enum;
  - the shared `uart_cfg_t` struct (`baud_div`, `parity_mode`, `two_stop`), reused by the successor transmitter.
- **Sub-module `uart_os_tick`:** the prescaler with synchronous restart. It will also be reused by the transmitter.

## Test plan
All scenarios use f_clk 12 MHz, OVERSAMPLE=16, `baud_div`=78 (9600 baud), `ready`=1 unless stated.
- **8N1 back-to-back:** 0xA5 then 0x3C with zero idle between frames → two `valid` pulses carrying 0xA5 and 0x3C, all flags 0.
- **Even parity:** `parity_mode`=1, 0x5B sent with parity bit 0 (correct value is 1) → `data_out`=0x5B, `parity_err`=1, `frame_err`=0.
- **Glitches:**
  - A 4-tick low pulse → no `valid`; `busy` returns to 0 after the START vote.
  - A single-tick 0 inside bit 3 of 0xFF → 0xFF received with no error (majority vote).
- **Break:** line held low for 20 bit times, then released → one word 0x00 with `brk`=1 and `frame_err`=1. The next frame, 0x41, is received normally.
- **Overrun:** `ready`=0, send 0x11 then 0x22 → `data_out` stays 0x11 and `overrun`=1. Pulse `ready` → 0x11 consumed. Pulse `overrun_clr` → `overrun`=0.
- **Reset mid-frame:** `rst` asserted during bit 4 → all outputs at reset values. A following 0x7E frame is received correctly.
